// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the I/D unified-memory arbiter.
// State and owner encodings are fixed so waveforms decode the same everywhere.
package mem_arbiter_pkg;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory macro signals.
// master = arbiter side, slave = pipeline/memory environment side.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_cancel;
  logic          i_done;
  logic [DW-1:0] i_rdata;
  logic          i_stall;
  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          d_stall;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;

  modport master (
    input  i_req, i_addr, i_cancel, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_done,
    output i_done, i_rdata, i_stall, d_done, d_rdata, d_stall,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, i_cancel, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_done,
    input  i_done, i_rdata, i_stall, d_done, d_rdata, d_stall,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_dff.sv
// Generic D flip-flop cell with asynchronous active-high reset to zero.
module mem_arb_dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Plain storage element; reset value is all zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_arbiter_streak.sv
// Saturating count of consecutive D grants while a fetch waits; raises force_i
// once the limit is reached so the next IDLE grant goes to I.
module mem_arb_streak #(
  parameter int MAX_D_STREAK = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_ok,
  input  logic d_grant,
  input  logic i_grant,
  output logic force_i
);

  localparam logic [2:0] MAX_S = 3'(MAX_D_STREAK);

  logic [2:0] streak_r;
  logic [2:0] streak_nxt_s;

  // Next count: clear when fetch is idle or served, else count D grants up to the limit.
  always_comb begin
    streak_nxt_s = streak_r;
    if (!i_req || i_grant) begin
      streak_nxt_s = 3'd0;
    end else if (d_grant && (streak_r < MAX_S)) begin
      streak_nxt_s = streak_r + 3'd1;
    end else begin
      streak_nxt_s = streak_r;
    end
  end

  mem_arb_dff #(.W(3)) u_streak_q (
    .clk (clk),
    .rst (rst),
    .d   (streak_nxt_s),
    .q   (streak_r)
  );

  assign force_i = i_ok & (streak_r == MAX_S);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for one single-port variable-latency memory shared by fetch (I) and
// memory stage (D). One access outstanding; D has priority, bounded by the streak.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int MAX_D_STREAK = 3
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [1:0] state_q_s;
  logic       kill_r;
  logic       kill_nxt_s;
  logic       i_ok_s;
  logic       force_i_s;
  logic       grant_d_s;
  logic       grant_i_s;
  owner_t     owner_s;

  assign i_ok_s  = bus.i_req & ~bus.i_cancel;
  assign state_r = state_t'(state_q_s);

  // IDLE grant decision; nothing is granted while reset is held.
  always_comb begin
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    owner_s   = OWN_I;
    if (!rst && (state_r == IDLE)) begin
      if (bus.d_req && !force_i_s) begin
        grant_d_s = 1'b1;
        owner_s   = OWN_D;
      end else if (i_ok_s) begin
        grant_i_s = 1'b1;
        owner_s   = OWN_I;
      end else begin
        owner_s   = OWN_I;
      end
    end else begin
      owner_s = OWN_I;
    end
  end

  mem_arb_streak #(.MAX_D_STREAK(MAX_D_STREAK)) u_streak (
    .clk     (clk),
    .rst     (rst),
    .i_req   (bus.i_req),
    .i_ok    (i_ok_s),
    .d_grant (grant_d_s),
    .i_grant (grant_i_s),
    .force_i (force_i_s)
  );

  // Command issue, completion routing, next state and kill tracking.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = {AW{1'b0}};
    bus.mem_wdata = {DW{1'b0}};
    bus.i_done    = 1'b0;
    bus.i_rdata   = {DW{1'b0}};
    bus.d_done    = 1'b0;
    bus.d_rdata   = {DW{1'b0}};
    state_nxt_s   = state_r;
    kill_nxt_s    = kill_r;
    if (rst) begin
      state_nxt_s = IDLE;
      kill_nxt_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_d_s || grant_i_s) begin
            bus.mem_en = 1'b1;
            case (owner_s)
              OWN_D: begin
                bus.mem_wr    = bus.d_wr;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
                state_nxt_s   = BUSY_D;
              end
              OWN_I: begin
                bus.mem_addr = bus.i_addr;
                state_nxt_s  = BUSY_I;
                kill_nxt_s   = kill_r | bus.i_cancel;
              end
              default: state_nxt_s = IDLE;
            endcase
          end else begin
            state_nxt_s = IDLE;
          end
        end
        BUSY_I: begin
          // A cancel landing with mem_done still suppresses this completion.
          if (bus.mem_done) begin
            bus.i_done  = ~kill_r & ~bus.i_cancel;
            bus.i_rdata = bus.i_done ? bus.mem_rdata : {DW{1'b0}};
            state_nxt_s = IDLE;
            kill_nxt_s  = 1'b0;
          end else begin
            kill_nxt_s = kill_r | bus.i_cancel;
          end
        end
        BUSY_D: begin
          if (bus.mem_done) begin
            bus.d_done  = 1'b1;
            bus.d_rdata = bus.mem_rdata;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = BUSY_D;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          kill_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  assign bus.i_stall = ~rst & bus.i_req & ~bus.i_done;
  assign bus.d_stall = ~rst & bus.d_req & ~bus.d_done;

  mem_arb_dff #(.W(2)) u_state_q (
    .clk (clk),
    .rst (rst),
    .d   (state_nxt_s),
    .q   (state_q_s)
  );

  mem_arb_dff #(.W(1)) u_kill_q (
    .clk (clk),
    .rst (rst),
    .d   (kill_nxt_s),
    .q   (kill_r)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge against hand-computed values.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_arbiter #(.AW(16), .DW(16), .MAX_D_STREAK(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.i_req = 1'b1;  bus.i_addr = 16'h0000; bus.i_cancel = 1'b0;
    bus.d_req = 1'b1;  bus.d_wr = 1'b0; bus.d_addr = 16'h0000; bus.d_wdata = 16'h0000;
    bus.mem_rdata = 16'h0000; bus.mem_done = 1'b0;

    // Reset: all outputs low even with requests pending
    smp();
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_i_stall", 32'(bus.i_stall), 32'd0);
    chk("rst_d_stall", 32'(bus.d_stall), 32'd0);
    nxt();
    nxt();
    rst = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0;
    smp();
    chk("post_rst_mem_en", 32'(bus.mem_en), 32'd0);

    // Single read, L = 2
    nxt(); bus.i_req = 1'b1; bus.i_addr = 16'h0010;
    smp();
    chk("rd_mem_en", 32'(bus.mem_en), 32'd1);
    chk("rd_mem_addr", 32'(bus.mem_addr), 32'h0010);
    chk("rd_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("rd_i_stall0", 32'(bus.i_stall), 32'd1);
    nxt();
    smp();
    chk("rd_mem_en_busy", 32'(bus.mem_en), 32'd0);
    chk("rd_i_stall1", 32'(bus.i_stall), 32'd1);
    chk("rd_i_done_early", 32'(bus.i_done), 32'd0);
    nxt(); bus.mem_done = 1'b1; bus.mem_rdata = 16'hA5A5;
    smp();
    chk("rd_i_done", 32'(bus.i_done), 32'd1);
    chk("rd_i_rdata", 32'(bus.i_rdata), 32'hA5A5);
    chk("rd_i_stall_done", 32'(bus.i_stall), 32'd0);
    nxt(); bus.mem_done = 1'b0; bus.i_req = 1'b0;
    smp();
    chk("rd_i_done_clr", 32'(bus.i_done), 32'd0);
    chk("rd_i_rdata_clr", 32'(bus.i_rdata), 32'h0000);

    // Collision, L = 1: D write first, I one cycle after d_done
    nxt(); bus.i_req = 1'b1; bus.i_addr = 16'h0020;
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0100; bus.d_wdata = 16'h1234;
    smp();
    chk("col_mem_en", 32'(bus.mem_en), 32'd1);
    chk("col_mem_wr", 32'(bus.mem_wr), 32'd1);
    chk("col_mem_addr", 32'(bus.mem_addr), 32'h0100);
    chk("col_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
    nxt(); bus.mem_done = 1'b1; bus.mem_rdata = 16'h0000;
    smp();
    chk("col_d_done", 32'(bus.d_done), 32'd1);
    chk("col_i_stall", 32'(bus.i_stall), 32'd1);
    chk("col_mem_en_busy", 32'(bus.mem_en), 32'd0);
    nxt(); bus.mem_done = 1'b0; bus.d_req = 1'b0; bus.d_wr = 1'b0;
    smp();
    chk("col_i_issue", 32'(bus.mem_en), 32'd1);
    chk("col_i_addr", 32'(bus.mem_addr), 32'h0020);
    chk("col_i_wdata", 32'(bus.mem_wdata), 32'h0000);
    nxt(); bus.mem_done = 1'b1; bus.mem_rdata = 16'hBEEF;
    smp();
    chk("col_i_done", 32'(bus.i_done), 32'd1);
    chk("col_i_rdata", 32'(bus.i_rdata), 32'hBEEF);
    nxt(); bus.mem_done = 1'b0; bus.i_req = 1'b0;

    // Starvation: three D grants, then I forced
    nxt(); bus.i_req = 1'b1; bus.i_addr = 16'h0030;
    bus.d_req = 1'b1; bus.d_addr = 16'h0200;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("stv_d_addr", 32'(bus.mem_addr), 32'h0200);
      nxt(); bus.mem_done = 1'b1; bus.mem_rdata = 16'(k + 1);
      smp();
      chk("stv_d_rdata", 32'(bus.d_rdata), 32'(k + 1));
      nxt(); bus.mem_done = 1'b0;
    end
    smp();
    chk("stv_force_i_en", 32'(bus.mem_en), 32'd1);
    chk("stv_force_i_addr", 32'(bus.mem_addr), 32'h0030);
    chk("stv_d_stall", 32'(bus.d_stall), 32'd1);
    nxt(); bus.mem_done = 1'b1; bus.mem_rdata = 16'h3030;
    smp();
    chk("stv_i_done", 32'(bus.i_done), 32'd1);
    // Streak back at 0: fresh I+D collision goes to D again
    nxt(); bus.mem_done = 1'b0; bus.d_addr = 16'h0300;
    smp();
    chk("stv_reset_d_addr", 32'(bus.mem_addr), 32'h0300);
    nxt(); bus.mem_done = 1'b1;
    smp();
    chk("stv_reset_d_done", 32'(bus.d_done), 32'd1);
    nxt(); bus.mem_done = 1'b0; bus.d_req = 1'b0;
    smp();
    chk("stv_tail_i_addr", 32'(bus.mem_addr), 32'h0030);
    nxt(); bus.mem_done = 1'b1;
    smp();
    chk("stv_tail_i_done", 32'(bus.i_done), 32'd1);
    nxt(); bus.mem_done = 1'b0; bus.i_req = 1'b0;

    // Cancel one cycle after issue, L = 3; redirected fetch waits for IDLE
    nxt(); bus.i_req = 1'b1; bus.i_addr = 16'h0050;
    smp();
    chk("can_issue_addr", 32'(bus.mem_addr), 32'h0050);
    nxt(); bus.i_cancel = 1'b1; bus.i_addr = 16'h0040;
    smp();
    chk("can_no_grant", 32'(bus.mem_en), 32'd0);
    nxt(); bus.i_cancel = 1'b0;
    smp();
    chk("can_busy", 32'(bus.mem_en), 32'd0);
    nxt(); bus.mem_done = 1'b1; bus.mem_rdata = 16'hDEAD;
    smp();
    chk("can_i_done_sup", 32'(bus.i_done), 32'd0);
    chk("can_i_rdata_zero", 32'(bus.i_rdata), 32'h0000);
    chk("can_i_stall", 32'(bus.i_stall), 32'd1);
    nxt(); bus.mem_done = 1'b0;
    smp();
    chk("can_new_en", 32'(bus.mem_en), 32'd1);
    chk("can_new_addr", 32'(bus.mem_addr), 32'h0040);
    nxt(); bus.mem_done = 1'b1; bus.mem_rdata = 16'h1111;
    smp();
    chk("can_new_done", 32'(bus.i_done), 32'd1);
    chk("can_new_rdata", 32'(bus.i_rdata), 32'h1111);
    // Cancel coinciding with mem_done
    nxt(); bus.mem_done = 1'b0; bus.i_addr = 16'h0060;
    smp();
    chk("can2_issue", 32'(bus.mem_addr), 32'h0060);
    nxt(); bus.mem_done = 1'b1; bus.i_cancel = 1'b1;
    smp();
    chk("can2_done_sup", 32'(bus.i_done), 32'd0);
    nxt(); bus.mem_done = 1'b0; bus.i_cancel = 1'b0; bus.i_req = 1'b0;
    smp();
    chk("can2_idle", 32'(bus.mem_en), 32'd0);

    // Reset while BUSY_D, stale mem_done afterwards
    nxt(); bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0400;
    smp();
    chk("rm_issue", 32'(bus.mem_en), 32'd1);
    nxt(); rst = 1'b1;
    smp();
    chk("rm_d_stall", 32'(bus.d_stall), 32'd0);
    chk("rm_mem_en", 32'(bus.mem_en), 32'd0);
    nxt(); rst = 1'b0; bus.d_req = 1'b0; bus.mem_done = 1'b1; bus.mem_rdata = 16'h7777;
    smp();
    chk("rm_stale_d_done", 32'(bus.d_done), 32'd0);
    chk("rm_stale_d_rdata", 32'(bus.d_rdata), 32'h0000);
    chk("rm_stale_mem_en", 32'(bus.mem_en), 32'd0);
    nxt(); bus.mem_done = 1'b0;

    // Idle with random stale responses
    for (int k = 0; k < 10; k++) begin
      nxt();
      bus.mem_done  = 1'($urandom_range(0, 1));
      bus.mem_rdata = 16'($urandom);
      smp();
      chk("idle_mem_en", 32'(bus.mem_en), 32'd0);
      chk("idle_dones", 32'({bus.i_done, bus.d_done}), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
